reg_port_sequencer: RTL and testbench

- Sits directly upstream of the single-port register file (16 general + 16 float registers, one read or one write per enabled cycle, registered read data).
- Serialises two traffic classes onto that one port:
  - Operand fetch requests: up to two sources each.
  - Writeback requests: one register write each.
- Returns fetched operand pairs to the execute stage over a valid/ready handshake.
- Guarantees a read issued after an accepted writeback sees the written value.

---
 rtl/reg_port_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reg_port_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module : reg_port_sequencer
// Serialises writebacks and two-source operand fetches onto one register-file port.
// Rev    : 1.0
// ============================================================================
module reg_port_sequencer #(
    parameter int DATA_W   = 32,
    parameter int REGNUM_W = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                src1_en,
    input  logic                src1_flt,
    input  logic [REGNUM_W-1:0] src1_num,
    input  logic                src2_en,
    input  logic                src2_flt,
    input  logic [REGNUM_W-1:0] src2_num,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic                wb_flt,
    input  logic [REGNUM_W-1:0] wb_num,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                opr_valid,
    input  logic                opr_ready,
    output logic [DATA_W-1:0]   opr_a,
    output logic [DATA_W-1:0]   opr_b,
    output logic                rf_enable,
    output logic                rf_rwflag,
    output logic                rf_gf_flag,
    output logic [REGNUM_W-1:0] rf_regnum,
    output logic [DATA_W-1:0]   rf_inp,
    input  logic [DATA_W-1:0]   rf_outp
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RD1   = 3'd2,
        S_RD2   = 3'd3,
        S_CAP   = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  rf_enable_q, rf_enable_d;
    logic                  rf_rwflag_q, rf_rwflag_d;
    logic                  rf_gf_flag_q, rf_gf_flag_d;
    logic [REGNUM_W-1:0]   rf_regnum_q, rf_regnum_d;
    logic [DATA_W-1:0]     rf_inp_q, rf_inp_d;
    logic                  opr_valid_q, opr_valid_d;
    logic [DATA_W-1:0]     opr_a_q, opr_a_d;
    logic [DATA_W-1:0]     opr_b_q, opr_b_d;
    logic                  src1_en_q, src1_en_d;
    logic                  src2_en_q, src2_en_d;
    logic                  src2_flt_q, src2_flt_d;
    logic [REGNUM_W-1:0]   src2_num_q, src2_num_d;

    // Ready outputs are gated by rstn so every output reads 0 while reset is held.
    assign wb_ready  = rstn & (state_q == S_IDLE);
    assign req_ready = rstn & (state_q == S_IDLE) & ~wb_valid;

    always_comb begin
        state_d      = state_q;
        rf_enable_d  = 1'b0;
        rf_rwflag_d  = rf_rwflag_q;
        rf_gf_flag_d = rf_gf_flag_q;
        rf_regnum_d  = rf_regnum_q;
        rf_inp_d     = rf_inp_q;
        opr_valid_d  = opr_valid_q;
        opr_a_d      = opr_a_q;
        opr_b_d      = opr_b_q;
        src1_en_d    = src1_en_q;
        src2_en_d    = src2_en_q;
        src2_flt_d   = src2_flt_q;
        src2_num_d   = src2_num_q;

        case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    rf_enable_d  = 1'b1;
                    rf_rwflag_d  = 1'b1;
                    rf_gf_flag_d = wb_flt;
                    rf_regnum_d  = wb_num;
                    rf_inp_d     = wb_data;
                    state_d      = S_WRITE;
                end else if (req_valid) begin
                    src1_en_d    = src1_en;
                    src2_en_d    = src2_en;
                    src2_flt_d   = src2_flt;
                    src2_num_d   = src2_num;
                    rf_enable_d  = src1_en;
                    rf_rwflag_d  = 1'b0;
                    rf_gf_flag_d = src1_flt;
                    rf_regnum_d  = src1_num;
                    state_d      = S_RD1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_RD1: begin
                rf_enable_d  = src2_en_q;
                rf_rwflag_d  = 1'b0;
                rf_gf_flag_d = src2_flt_q;
                rf_regnum_d  = src2_num_q;
                state_d      = S_RD2;
            end
            S_RD2: begin
                // rf_outp now carries the source-1 read issued in RD1's cycle.
                opr_a_d = src1_en_q ? rf_outp : '0;
                state_d = S_CAP;
            end
            S_CAP: begin
                opr_b_d     = src2_en_q ? rf_outp : '0;
                opr_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (opr_ready) begin
                    opr_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rf_enable_q  <= 1'b0;
            rf_rwflag_q  <= 1'b0;
            rf_gf_flag_q <= 1'b0;
            rf_regnum_q  <= '0;
            rf_inp_q     <= '0;
            opr_valid_q  <= 1'b0;
            opr_a_q      <= '0;
            opr_b_q      <= '0;
            src1_en_q    <= 1'b0;
            src2_en_q    <= 1'b0;
            src2_flt_q   <= 1'b0;
            src2_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            rf_enable_q  <= rf_enable_d;
            rf_rwflag_q  <= rf_rwflag_d;
            rf_gf_flag_q <= rf_gf_flag_d;
            rf_regnum_q  <= rf_regnum_d;
            rf_inp_q     <= rf_inp_d;
            opr_valid_q  <= opr_valid_d;
            opr_a_q      <= opr_a_d;
            opr_b_q      <= opr_b_d;
            src1_en_q    <= src1_en_d;
            src2_en_q    <= src2_en_d;
            src2_flt_q   <= src2_flt_d;
            src2_num_q   <= src2_num_d;
        end
    end

    assign rf_enable  = rf_enable_q;
    assign rf_rwflag  = rf_rwflag_q;
    assign rf_gf_flag = rf_gf_flag_q;
    assign rf_regnum  = rf_regnum_q;
    assign rf_inp     = rf_inp_q;
    assign opr_valid  = opr_valid_q;
    assign opr_a      = opr_a_q;
    assign opr_b      = opr_b_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_port_sequencer
// Drives reg_port_sequencer against a behavioural register file and a shadow model.
// Rev    : 1.0
// ============================================================================
module tb_reg_port_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        src1_en = 1'b0, src1_flt = 1'b0, src2_en = 1'b0, src2_flt = 1'b0;
    logic [3:0]  src1_num = '0, src2_num = '0;
    logic        wb_valid = 1'b0, wb_flt = 1'b0;
    logic        wb_ready;
    logic [3:0]  wb_num = '0;
    logic [31:0] wb_data = '0;
    logic        opr_valid, opr_ready = 1'b0;
    logic [31:0] opr_a, opr_b;
    logic        rf_enable, rf_rwflag, rf_gf_flag;
    logic [3:0]  rf_regnum;
    logic [31:0] rf_inp;
    logic [31:0] rf_outp = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_port_sequencer #(.DATA_W(32), .REGNUM_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .src1_en(src1_en), .src1_flt(src1_flt), .src1_num(src1_num),
        .src2_en(src2_en), .src2_flt(src2_flt), .src2_num(src2_num),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_flt(wb_flt),
        .wb_num(wb_num), .wb_data(wb_data),
        .opr_valid(opr_valid), .opr_ready(opr_ready), .opr_a(opr_a), .opr_b(opr_b),
        .rf_enable(rf_enable), .rf_rwflag(rf_rwflag), .rf_gf_flag(rf_gf_flag),
        .rf_regnum(rf_regnum), .rf_inp(rf_inp), .rf_outp(rf_outp)
    );

    // Behavioural single-port register file; also counts read-enabled cycles.
    logic [31:0] rf_mem [0:31] = '{default: 32'h0};
    int rd_cnt = 0;
    always @(posedge clk) begin
        if (rf_enable) begin
            if (rf_rwflag) rf_mem[{rf_gf_flag, rf_regnum}] <= rf_inp;
            else begin
                rf_outp <= rf_mem[{rf_gf_flag, rf_regnum}];
                rd_cnt  <= rd_cnt + 1;
            end
        end
    end

    // Architectural register state as seen by the producer of writebacks.
    logic [31:0] shadow [0:31];
    logic [31:0] last_wb_data = '0;

    task automatic do_wb(input logic flt, input logic [3:0] num, input logic [31:0] data,
                         output bit ok);
        int t = 0;
        @(negedge clk);
        wb_valid = 1'b1; wb_flt = flt; wb_num = num; wb_data = data;
        while (!wb_ready && t < 20) begin @(negedge clk); t++; end
        ok = wb_ready;
        if (ok) begin
            @(posedge clk);
            shadow[{flt, num}] = data;
            last_wb_data = data;
            @(negedge clk);
        end
        wb_valid = 1'b0;
    endtask

    task automatic fetch(input logic e1, input logic f1, input logic [3:0] n1,
                         input logic e2, input logic f2, input logic [3:0] n2,
                         input bit ack,
                         output logic [31:0] a, output logic [31:0] b,
                         output int lat, output int rds, output bit ok);
        int t = 0;
        int base;
        @(negedge clk);
        req_valid = 1'b1;
        src1_en = e1; src1_flt = f1; src1_num = n1;
        src2_en = e2; src2_flt = f2; src2_num = n2;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        ok = req_ready;
        a = '0; b = '0; lat = 0; rds = 0;
        if (!ok) begin req_valid = 1'b0; return; end
        base = rd_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (!opr_valid && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        ok = opr_valid;
        a = opr_a; b = opr_b;
        if (ok && ack) begin
            opr_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            opr_ready = 1'b0;
        end
        rds = rd_cnt - base;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if ({req_ready, wb_ready, opr_valid, rf_enable, rf_rwflag, rf_gf_flag,
             rf_regnum, rf_inp, opr_a, opr_b} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero during reset");
        end
        @(negedge clk); rstn = 1'b1; #1;
        checks++;
        if ({req_ready, wb_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b want 11", {req_ready, wb_ready});
        end
    endtask

    task automatic test_single();
        logic [31:0] a, b; int lat, rds; bit ok, okw;
        do_wb(1'b0, 4'd3, 32'hDEADBEEF, okw);
        fetch(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b1, a, b, lat, rds, ok);
        checks++;
        if (!(ok && okw) || a !== 32'hDEADBEEF || b !== 32'h0) begin
            errors++; $display("FAIL single_fetch: a=%h b=%h want DEADBEEF 00000000", a, b);
        end
        checks++;
        if (lat !== 3 || rds !== 1) begin
            errors++; $display("FAIL single_latency: lat=%0d rds=%0d want 3 1", lat, rds);
        end
        checks++;
        if (rf_inp !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rf_inp_hold: got %h want DEADBEEF", rf_inp);
        end
    endtask

    task automatic test_banks();
        logic [31:0] a, b; int lat, rds; bit ok, ok1, ok2;
        do_wb(1'b1, 4'd3, 32'h3F800000, ok1);
        do_wb(1'b0, 4'd3, 32'h00000001, ok2);
        fetch(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, a, b, lat, rds, ok);
        checks++;
        if (!(ok && ok1 && ok2) || a !== 32'h3F800000 || b !== 32'h00000001) begin
            errors++; $display("FAIL banks: a=%h b=%h want 3F800000 00000001", a, b);
        end
    endtask

    task automatic test_priority();
        logic [31:0] a, b; int lat, rds; bit ok;
        @(negedge clk);
        wb_valid = 1'b1; wb_flt = 1'b0; wb_num = 4'd7; wb_data = 32'h12345678;
        req_valid = 1'b1; src1_en = 1'b1; src1_flt = 1'b0; src1_num = 4'd7; src2_en = 1'b0;
        #1;
        checks++;
        if ({wb_ready, req_ready} !== 2'b10) begin
            errors++; $display("FAIL prio_ready: wb/req=%b want 10", {wb_ready, req_ready});
        end
        @(posedge clk);
        shadow[{1'b0, 4'd7}] = 32'h12345678;
        @(negedge clk);
        wb_valid = 1'b0; req_valid = 1'b0;
        checks++;
        if ({rf_enable, rf_rwflag, rf_regnum} !== {2'b11, 4'd7}) begin
            errors++; $display("FAIL prio_write_first: en/rw/num=%b want 110111",
                               {rf_enable, rf_rwflag, rf_regnum});
        end
        fetch(1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 4'd0, 1'b1, a, b, lat, rds, ok);
        checks++;
        if (!ok || a !== 32'h12345678) begin
            errors++; $display("FAIL prio_read: a=%h want 12345678", a);
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b; int lat, rds; bit ok;
        fetch(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd7, 1'b0, a, b, lat, rds, ok);
        checks++;
        if (!ok || a !== shadow[{1'b1, 4'd3}] || b !== shadow[{1'b0, 4'd7}]) begin
            errors++; $display("FAIL hold_values: a=%h b=%h", a, b);
        end
        req_valid = 1'b1; src1_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({opr_valid, req_ready, wb_ready, rf_enable} !== 4'b1000 ||
                opr_a !== a || opr_b !== b) begin
                errors++; $display("FAIL hold_stable[%0d]: v/rr/wr/en=%b a=%h b=%h", i,
                                   {opr_valid, req_ready, wb_ready, rf_enable}, opr_a, opr_b);
            end
        end
        req_valid = 1'b0;
        opr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        opr_ready = 1'b0;
        checks++;
        if ({opr_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL hold_release: valid/req_ready=%b want 01",
                               {opr_valid, req_ready});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b; int lat, rds; bit ok;
        @(negedge clk);
        req_valid = 1'b1; src1_en = 1'b1; src1_flt = 1'b0; src1_num = 4'd3;
        src2_en = 1'b1; src2_flt = 1'b1; src2_num = 4'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({rf_enable, opr_valid, req_ready, wb_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid: en/v/rr/wr=%b want 0000",
                               {rf_enable, opr_valid, req_ready, wb_ready});
        end
        @(negedge clk); rstn = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: got %b want 1", req_ready);
        end
        fetch(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b1, a, b, lat, rds, ok);
        checks++;
        if (!ok || a !== shadow[{1'b0, 4'd3}]) begin
            errors++; $display("FAIL reset_mid_reread: a=%h want %h", a, shadow[{1'b0, 4'd3}]);
        end
    endtask

    task automatic test_same_and_none();
        logic [31:0] a, b; int lat, rds; bit ok, okw;
        do_wb(1'b0, 4'd15, 32'hA5A5A5A5, okw);
        fetch(1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, a, b, lat, rds, ok);
        checks++;
        if (!(ok && okw) || a !== 32'hA5A5A5A5 || b !== 32'hA5A5A5A5 || rds !== 2) begin
            errors++; $display("FAIL same_reg: a=%h b=%h rds=%0d want A5A5A5A5 x2 2", a, b, rds);
        end
        fetch(1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 4'd15, 1'b1, a, b, lat, rds, ok);
        checks++;
        if (!ok || a !== 32'h0 || b !== 32'h0 || rds !== 0 || lat !== 3) begin
            errors++; $display("FAIL no_src: a=%h b=%h rds=%0d lat=%0d want 0 0 0 3",
                               a, b, rds, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, ea, eb; int lat, rds; bit ok;
        logic e1, f1, e2, f2; logic [3:0] n1, n2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_wb(1'($urandom), 4'($urandom), $urandom, ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL rand_wb[%0d]: not accepted", i); end
            end else begin
                e1 = 1'($urandom); f1 = 1'($urandom); n1 = 4'($urandom);
                e2 = 1'($urandom); f2 = 1'($urandom); n2 = 4'($urandom);
                ea = e1 ? shadow[{f1, n1}] : 32'h0;
                eb = e2 ? shadow[{f2, n2}] : 32'h0;
                fetch(e1, f1, n1, e2, f2, n2, 1'b1, a, b, lat, rds, ok);
                checks++;
                if (!ok || a !== ea || b !== eb || lat !== 3 || rds !== int'(e1) + int'(e2)) begin
                    errors++;
                    $display("FAIL rand_fetch[%0d]: a=%h b=%h lat=%0d rds=%0d want %h %h 3 %0d",
                             i, a, b, lat, rds, ea, eb, int'(e1) + int'(e2));
                end
            end
        end
        checks++;
        if (rf_inp !== last_wb_data) begin
            errors++; $display("FAIL rand_rf_inp: got %h want %h", rf_inp, last_wb_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
        test_reset();
        test_single();
        test_banks();
        test_priority();
        test_hold();
        test_reset_mid();
        test_same_and_none();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
